// File: rtl/packet_ejector_pkg.sv
// Shared parameters for the ejection endpoint: flit geometry, flit-type codes
// and the ejector FSM state encoding.
package packet_ejector_pkg;

    localparam int DW          = 32;
    localparam int PKT_LEN     = 8;
    localparam int PKT_LEN_LOG = 3;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BODY = 2'b01,
        ST_DROP = 2'b10
    } ej_state_t;

endpackage

// File: rtl/packet_ejector_if.sv
// Network-side and PE-side handshake bundle of the packet ejector.
interface packet_ejector_if;
    import packet_ejector_pkg::*;

    logic          valid_i_nw;
    logic [DW-1:0] data_i_nw;
    logic          ready_o_nw;
    logic          valid_o_pe;
    logic [DW-1:0] data_o_pe;
    logic          ready_i_pe;
    logic [9:0]    sid_o;
    logic          pkt_done_o;
    logic          err_o;

    modport slave (
        input  valid_i_nw, data_i_nw, ready_i_pe,
        output ready_o_nw, valid_o_pe, data_o_pe, sid_o, pkt_done_o, err_o
    );

    modport master (
        output valid_i_nw, data_i_nw, ready_i_pe,
        input  ready_o_nw, valid_o_pe, data_o_pe, sid_o, pkt_done_o, err_o
    );

endinterface

// File: rtl/packet_ejector_commit_fifo.sv
// First-word-fall-through payload FIFO whose writes stay invisible to the
// reader until committed; an abort rolls the speculative pointer back.
module commit_fifo
    import packet_ejector_pkg::*;
#(
    parameter int WIDTH = DW,
    parameter int DEPTH = 2 * (PKT_LEN - 2),
    parameter int PTR_W = PKT_LEN_LOG + 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             write,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             abort,
    input  logic             read,
    output logic [WIDTH-1:0] rd_data,
    output logic             spec_full,
    output logic             empty
);

    localparam int IW = PTR_W - 1;

    // Top bit flips on every modulo-DEPTH wrap so full and empty stay distinct.
    typedef struct packed {
        logic          wrap;
        logic [IW-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p.idx == IW'(DEPTH - 1)) begin
            r.wrap = ~p.wrap;
            r.idx  = {IW{1'b0}};
        end else begin
            r.wrap = p.wrap;
            r.idx  = p.idx + IW'(1);
        end
        return r;
    endfunction

    ptr_t             spec_wr_r;
    ptr_t             cmt_wr_r;
    ptr_t             rd_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign spec_full = (spec_wr_r.idx == rd_r.idx) && (spec_wr_r.wrap != rd_r.wrap);
    assign empty     = (cmt_wr_r == rd_r);
    assign push_s    = write && !spec_full;
    assign pop_s     = read && !empty;
    assign rd_data   = empty ? {WIDTH{1'b0}} : mem_r[rd_r.idx];

    // Pointer registers: speculative, committed and read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spec_wr_r <= '{wrap: 1'b0, idx: {IW{1'b0}}};
            cmt_wr_r  <= '{wrap: 1'b0, idx: {IW{1'b0}}};
            rd_r      <= '{wrap: 1'b0, idx: {IW{1'b0}}};
        end else begin
            if (abort) begin
                spec_wr_r <= cmt_wr_r;
            end else if (push_s) begin
                spec_wr_r <= ptr_inc(spec_wr_r);
            end
            if (commit) begin
                cmt_wr_r <= spec_wr_r;
            end
            if (pop_s) begin
                rd_r <= ptr_inc(rd_r);
            end
        end
    end

    // Payload storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[spec_wr_r.idx] <= wr_data;
        end
    end

endmodule

// File: rtl/packet_ejector.sv
// Store-and-forward ejection endpoint: validates HEAD/BODY/TAIL framing and
// hands only complete packets' BODY flits to the PE. Optional SID filter: EJECT_SID_CHECK_EN.
module packet_ejector
    import packet_ejector_pkg::*;
#(
    parameter logic [9:0] EXP_SID       = 10'd0,
    parameter int         PAY_DEPTH     = 2 * (PKT_LEN - 2),
    parameter int         PAY_DEPTH_LOG = PKT_LEN_LOG + 2
) (
    input logic             clk,
    input logic             rstn,
    packet_ejector_if.slave bus
);

    localparam logic [PKT_LEN_LOG-1:0] BODY_MAX = PKT_LEN_LOG'(PKT_LEN - 2);

    ej_state_t              state_r;
    ej_state_t              state_s;
    logic [PKT_LEN_LOG-1:0] body_cnt_r;
    logic [PKT_LEN_LOG-1:0] body_cnt_s;
    logic [9:0]             pending_sid_r;
    logic [9:0]             pending_sid_s;
    logic [9:0]             sid_r;
    logic                   done_r;
    logic                   err_r;
    logic                   accept_s;
    logic                   wr_s;
    logic                   commit_s;
    logic                   abort_s;
    logic                   set_err_s;
    logic                   head_ok_s;
    logic                   spec_full_s;
    logic                   empty_s;
    logic [1:0]             flit_type_s;
    logic [9:0]             flit_sid_s;
    logic [DW-1:0]          rd_data_s;

    assign flit_type_s = bus.data_i_nw[DW-1 -: 2];
    assign flit_sid_s  = bus.data_i_nw[9:0];
    assign accept_s    = bus.valid_i_nw && bus.ready_o_nw;

`ifdef EJECT_SID_CHECK_EN
    assign head_ok_s = (flit_sid_s == EXP_SID);
`else
    logic unused_exp_sid_s;
    assign unused_exp_sid_s = ^EXP_SID;
    assign head_ok_s        = 1'b1;
`endif

    // Framing FSM: next state, payload write, commit/abort and error strobes.
    always_comb begin
        state_s       = state_r;
        body_cnt_s    = body_cnt_r;
        pending_sid_s = pending_sid_r;
        wr_s          = 1'b0;
        commit_s      = 1'b0;
        abort_s       = 1'b0;
        set_err_s     = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_BODY: begin
                    case (flit_type_s)
                        BODY: begin
                            if (body_cnt_r < BODY_MAX) begin
                                wr_s       = 1'b1;
                                body_cnt_s = body_cnt_r + PKT_LEN_LOG'(1);
                            end else begin
                                abort_s   = 1'b1;
                                set_err_s = 1'b1;
                                state_s   = ST_DROP;
                            end
                        end
                        TAIL: begin
                            if (body_cnt_r == BODY_MAX) begin
                                commit_s = 1'b1;
                            end else begin
                                abort_s   = 1'b1;
                                set_err_s = 1'b1;
                            end
                            state_s = ST_IDLE;
                        end
                        HEAD: begin
                            abort_s   = 1'b1;
                            set_err_s = 1'b1;
                            if (head_ok_s) begin
                                pending_sid_s = flit_sid_s;
                                body_cnt_s    = {PKT_LEN_LOG{1'b0}};
                                state_s       = ST_BODY;
                            end else begin
                                state_s = ST_DROP;
                            end
                        end
                        default: begin
                            abort_s   = 1'b1;
                            set_err_s = 1'b1;
                            state_s   = ST_DROP;
                        end
                    endcase
                end
                ST_IDLE, ST_DROP: begin
                    // Stray BODY/TAIL flag an error in IDLE but are silently eaten in DROP.
                    case (flit_type_s)
                        HEAD: begin
                            if (head_ok_s) begin
                                pending_sid_s = flit_sid_s;
                                body_cnt_s    = {PKT_LEN_LOG{1'b0}};
                                state_s       = ST_BODY;
                            end else begin
                                set_err_s = 1'b1;
                                state_s   = ST_DROP;
                            end
                        end
                        TAIL: begin
                            set_err_s = (state_r == ST_IDLE);
                            state_s   = ST_IDLE;
                        end
                        default: begin
                            set_err_s = (state_r == ST_IDLE);
                        end
                    endcase
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM and packet-context registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            body_cnt_r    <= {PKT_LEN_LOG{1'b0}};
            pending_sid_r <= 10'd0;
        end else begin
            state_r       <= state_s;
            body_cnt_r    <= body_cnt_s;
            pending_sid_r <= pending_sid_s;
        end
    end

    // Status outputs: committed SID, commit pulse and sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sid_r  <= 10'd0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            sid_r  <= commit_s ? pending_sid_r : sid_r;
            done_r <= commit_s;
            err_r  <= err_r | set_err_s;
        end
    end

    commit_fifo #(
        .WIDTH (DW),
        .DEPTH (PAY_DEPTH),
        .PTR_W (PAY_DEPTH_LOG)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .write     (wr_s),
        .wr_data   (bus.data_i_nw),
        .commit    (commit_s),
        .abort     (abort_s),
        .read      (bus.ready_i_pe),
        .rd_data   (rd_data_s),
        .spec_full (spec_full_s),
        .empty     (empty_s)
    );

    assign bus.ready_o_nw = ~spec_full_s;
    assign bus.valid_o_pe = ~empty_s;
    assign bus.data_o_pe  = rd_data_s;
    assign bus.sid_o      = sid_r;
    assign bus.pkt_done_o = done_r;
    assign bus.err_o      = err_r;

endmodule

// File: tb/tb_packet_ejector.sv
// Directed plus randomized bench for packet_ejector, checked every cycle against
// a packet-level reference model built from queues.
module tb_packet_ejector;
    import packet_ejector_pkg::*;

    localparam int PAY_DEPTH = 2 * (PKT_LEN - 2);
`ifdef EJECT_SID_CHECK_EN
    localparam logic [9:0] TB_EXP_SID = 10'd3;
    localparam logic [9:0] SID_CLEAN  = 10'd3;
    localparam logic [9:0] SID_A      = 10'd3;
    localparam logic [9:0] SID_B      = 10'd3;
`else
    localparam logic [9:0] TB_EXP_SID = 10'd0;
    localparam logic [9:0] SID_CLEAN  = 10'h005;
    localparam logic [9:0] SID_A      = 10'h00A;
    localparam logic [9:0] SID_B      = 10'h00B;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    packet_ejector_if bus();

    packet_ejector #(
        .EXP_SID       (TB_EXP_SID),
        .PAY_DEPTH     (PAY_DEPTH),
        .PAY_DEPTH_LOG (PKT_LEN_LOG + 2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int rd_cnt  = 0;
    int pe_hold = 0;
    bit rand_pe = 1'b0;
    bit saw_full;

    // Reference model: committed payload awaiting the PE, and the open packet.
    logic [31:0] exp_q[$];
    logic [31:0] cur_q[$];
    bit          m_open, m_drop, m_err;
    logic [9:0]  m_sid, m_cur_sid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_q.delete();
        m_open = 1'b0; m_drop = 1'b0; m_err = 1'b0;
        m_sid = 10'd0; m_cur_sid = 10'd0;
    endtask

    task automatic model_flit(input logic [31:0] d, output bit done);
        logic [1:0] t;
        t = d[31:30];
        done = 1'b0;
        if (t == HEAD) begin
            if (m_open) m_err = 1'b1;
            cur_q.delete();
            m_open = 1'b1; m_drop = 1'b0; m_cur_sid = d[9:0];
`ifdef EJECT_SID_CHECK_EN
            if (d[9:0] != TB_EXP_SID) begin
                m_err = 1'b1; m_open = 1'b0; m_drop = 1'b1;
            end
`endif
        end else if (t == BODY) begin
            if (m_open) begin
                if (cur_q.size() < PKT_LEN - 2) cur_q.push_back(d);
                else begin
                    m_err = 1'b1; cur_q.delete(); m_open = 1'b0; m_drop = 1'b1;
                end
            end else if (!m_drop) m_err = 1'b1;
        end else if (t == TAIL) begin
            if (m_open) begin
                if (cur_q.size() == PKT_LEN - 2) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    m_sid = m_cur_sid;
                    done  = 1'b1;
                end else m_err = 1'b1;
                cur_q.delete();
                m_open = 1'b0;
            end else if (m_drop) m_drop = 1'b0;
            else m_err = 1'b1;
        end
    endtask

    task automatic check_outputs(input bit done);
        chk("valid_o_pe", 32'(bus.valid_o_pe), 32'(exp_q.size() != 0));
        chk("data_o_pe", bus.data_o_pe, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
        chk("ready_o_nw", 32'(bus.ready_o_nw), 32'((exp_q.size() + cur_q.size()) < PAY_DEPTH));
        chk("pkt_done_o", 32'(bus.pkt_done_o), 32'(done));
        chk("err_o", 32'(bus.err_o), 32'(m_err));
        chk("sid_o", 32'(bus.sid_o), 32'(m_sid));
    endtask

    // One clock: note handshakes, advance, update model, check every output.
    task automatic cycle(output bit acc);
        bit pe_rd;
        bit done;
        logic [31:0] d;
        acc   = bus.valid_i_nw && bus.ready_o_nw;
        pe_rd = bus.valid_o_pe && bus.ready_i_pe;
        d     = bus.data_i_nw;
        if (!bus.ready_o_nw) saw_full = 1'b1;
        @(posedge clk);
        #1;
        if (pe_rd && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            rd_cnt++;
        end
        done = 1'b0;
        if (acc) model_flit(d, done);
        if (pe_hold > 0) begin
            pe_hold--;
            bus.ready_i_pe = (pe_hold == 0);
        end else if (rand_pe) begin
            bus.ready_i_pe = 1'($urandom_range(0, 1));
        end
        check_outputs(done);
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.valid_i_nw = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic send_flit(input logic [1:0] t, input logic [29:0] payload);
        bit acc;
        int n;
        n   = 0;
        acc = 1'b0;
        bus.valid_i_nw = 1'b1;
        bus.data_i_nw  = {t, payload};
        while (!acc && n < 200) begin
            cycle(acc);
            n++;
        end
        if (!acc) chk("nw_accept_timeout", 32'(acc), 32'd1);
        bus.valid_i_nw = 1'b0;
    endtask

    task automatic send_pkt(input logic [9:0] sid, input int nbody, input bit tail, input int base);
        send_flit(HEAD, {20'd0, sid});
        for (int i = 0; i < nbody; i++) send_flit(BODY, 30'(base + i));
        if (tail) send_flit(TAIL, 30'd0);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        rand_pe = 1'b0;
        pe_hold = 0;
        bus.ready_i_pe = 1'b1;
        bus.valid_i_nw = 1'b0;
        while (exp_q.size() > 0 && n < 200) begin
            cycle(acc);
            n++;
        end
        idle(2);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.valid_i_nw = 1'b0;
        bus.ready_i_pe = 1'b1;
        pe_hold = 0;
        model_reset();
        #1;
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rsid;
        int nb;
        bit tl;
        bus.valid_i_nw = 1'b0;
        bus.data_i_nw  = 32'd0;
        bus.ready_i_pe = 1'b1;
        do_reset();

        // Clean packet with payload 1..6.
        rd_cnt = 0;
        send_pkt(SID_CLEAN, 6, 1'b1, 1);
        drain();
        chk("clean_reads", 32'(rd_cnt), 32'(((SID_CLEAN == TB_EXP_SID) || (TB_EXP_SID == 10'd0)) ? 6 : 0));

        // Short packet, then a clean one.
        send_pkt(SID_CLEAN, 3, 1'b1, 100);
        idle(3);
        chk("short_err", 32'(bus.err_o), 32'd1);
        rd_cnt = 0;
        send_pkt(SID_CLEAN, 6, 1'b1, 200);
        drain();
        chk("after_short_reads", 32'(rd_cnt), 32'd6);

        // Early HEAD: only B survives.
        rd_cnt = 0;
        send_pkt(SID_A, 2, 1'b0, 300);
        send_pkt(SID_B, 6, 1'b1, 400);
        drain();
        chk("early_head_reads", 32'(rd_cnt), 32'd6);
        chk("early_head_sid", 32'(bus.sid_o), 32'(SID_B));

        // Backpressure: three packets with the PE stalled for a while.
        rd_cnt = 0;
        saw_full = 1'b0;
        bus.ready_i_pe = 1'b0;
        pe_hold = 40;
        send_pkt(SID_CLEAN, 6, 1'b1, 500);
        send_pkt(SID_CLEAN, 6, 1'b1, 600);
        send_pkt(SID_CLEAN, 6, 1'b1, 700);
        drain();
        chk("bp_ready_dropped", 32'(saw_full), 32'd1);
        chk("bp_reads", 32'(rd_cnt), 32'd18);

        // Reset in the middle of a packet.
        send_pkt(SID_CLEAN, 4, 1'b0, 800);
        do_reset();
        rd_cnt = 0;
        send_pkt(SID_CLEAN, 6, 1'b1, 900);
        drain();
        chk("post_reset_reads", 32'(rd_cnt), 32'd6);

`ifdef EJECT_SID_CHECK_EN
        rd_cnt = 0;
        send_pkt(10'd4, 6, 1'b1, 1000);
        idle(3);
        chk("sid_bad_err", 32'(bus.err_o), 32'd1);
        chk("sid_bad_reads", 32'(rd_cnt), 32'd0);
        send_pkt(10'd3, 6, 1'b1, 1100);
        drain();
        chk("sid_good_reads", 32'(rd_cnt), 32'd6);
        chk("sid_good_sid", 32'(bus.sid_o), 32'd3);
`endif

        // Randomized traffic with random PE readiness.
        rand_pe = 1'b1;
        for (int p = 0; p < 40; p++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 8)) : 6;
            tl = ($urandom_range(0, 7) != 0);
`ifdef EJECT_SID_CHECK_EN
            rsid = ($urandom_range(0, 1) == 0) ? 10'd3 : 10'($urandom_range(0, 1023));
`else
            rsid = 10'($urandom_range(0, 1023));
`endif
            send_pkt(rsid, nb, tl, int'($urandom_range(0, 100000)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            rand_pe = 1'b1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
